asrv32_regfile: RTL and testbench

//   Parametrised integer register file for the asrv32 core; supports RV32I (32 regs) and RV32E (16 regs).
//   Two synchronous read ports with registered data outputs, one write port, and optional write-to-read bypass.

---
 rtl/asrv32_regfile.sv | 137 +++++++++++++
 tb/tb_asrv32_regfile.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/asrv32_regfile.sv
// asrv32_regfile -- integer register file for the asrv32 core (RV32I / RV32E).
//
// Two synchronous read ports with registered outputs, one write port and an
// optional write-to-read bypass. After reset (or an i_clear request) a sweep
// state machine writes zero into x1..x(NREGS-1); the file reports o_ready
// once the sweep has finished. x0 is hard-wired to zero and never stored.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_clear      synchronous request to re-run the clear sweep
//   i_ce_rd      read enable (captures both read ports)
//   i_ce_wr      write enable
//   i_rs1_addr   read port 1 address
//   i_rs2_addr   read port 2 address
//   i_rd_addr    write address
//   i_rd_data    write data
//   o_rs1_data   registered read data, port 1
//   o_rs2_data   registered read data, port 2
//   o_ready      1 when the file is usable, 0 during the clear sweep
//   o_addr_err   1-cycle pulse: an enabled access used an address >= NREGS
module asrv32_regfile #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_ce_rd,
    input  logic            i_ce_wr,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    input  logic [4:0]      i_rd_addr,
    input  logic [XLEN-1:0] i_rd_data,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_ready,
    output logic            o_addr_err
);

    localparam int unsigned AW = 5;
    localparam int unsigned IW = $clog2(NREGS);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t            state;
    logic [AW-1:0]     idx;
    logic [XLEN-1:0]   regs [NREGS];

    logic [AW-1:0]     raddr [2];
    logic [XLEN-1:0]   rval  [2];
    logic              wr_en;
    logic              err_nxt;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NREGS;
    endfunction

    assign raddr[0] = i_rs1_addr;
    assign raddr[1] = i_rs2_addr;

    // Read value resolution: x0 and out-of-range addresses read as zero,
    // then the optional bypass, then storage.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rval[p] = '0;
            if (raddr[p] != '0 && in_range(raddr[p])) begin
                if (BYPASS && i_ce_wr && raddr[p] == i_rd_addr) begin
                    rval[p] = i_rd_data;
                end else begin
                    rval[p] = regs[raddr[p][IW-1:0]];
                end
            end
        end
    end

    always_comb begin
        wr_en   = (state == S_READY) && !i_clear && i_ce_wr &&
                  (i_rd_addr != '0) && in_range(i_rd_addr);
        err_nxt = (i_ce_rd && (!in_range(i_rs1_addr) || !in_range(i_rs2_addr))) ||
                  (i_ce_wr && !in_range(i_rd_addr));
    end

    // Storage has no reset; the sweep defines its contents.
    always_ff @(posedge i_clk) begin
        if (state == S_CLEAR) begin
            regs[idx[IW-1:0]] <= '0;
        end else if (wr_en) begin
            regs[i_rd_addr[IW-1:0]] <= i_rd_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_CLEAR;
            idx        <= AW'(1);
            o_ready    <= 1'b0;
            o_rs1_data <= '0;
            o_rs2_data <= '0;
            o_addr_err <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    o_addr_err <= 1'b0;
                    // Last index written this edge: ready from the next cycle.
                    if (idx == AW'(NREGS - 1)) begin
                        state   <= S_READY;
                        o_ready <= 1'b1;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                S_READY: begin
                    if (i_clear) begin
                        state      <= S_CLEAR;
                        idx        <= AW'(1);
                        o_ready    <= 1'b0;
                        o_rs1_data <= '0;
                        o_rs2_data <= '0;
                        o_addr_err <= 1'b0;
                    end else begin
                        o_addr_err <= err_nxt;
                        if (i_ce_rd) begin
                            o_rs1_data <= rval[0];
                            o_rs2_data <= rval[1];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asrv32_regfile.sv
module tb_asrv32_regfile;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        clear   = 1'b0;
    logic        ce_rd   = 1'b0;
    logic        ce_wr   = 1'b0;
    logic [4:0]  rs1     = '0;
    logic [4:0]  rs2     = '0;
    logic [4:0]  rd      = '0;
    logic [31:0] wdata   = '0;

    logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2, c_rs1, c_rs2;
    logic        a_rdy, a_err, b_rdy, b_err, c_rdy, c_err;

    always #5 clk = ~clk;

    // a: RV32I with bypass, b: RV32I without bypass, c: RV32E with bypass
    asrv32_regfile #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_ce_rd(ce_rd), .i_ce_wr(ce_wr),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rd_addr(rd), .i_rd_data(wdata),
        .o_rs1_data(a_rs1), .o_rs2_data(a_rs2), .o_ready(a_rdy), .o_addr_err(a_err));
    asrv32_regfile #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_ce_rd(ce_rd), .i_ce_wr(ce_wr),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rd_addr(rd), .i_rd_data(wdata),
        .o_rs1_data(b_rs1), .o_rs2_data(b_rs2), .o_ready(b_rdy), .o_addr_err(b_err));
    asrv32_regfile #(.XLEN(32), .NREGS(16), .BYPASS(1'b1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_ce_rd(ce_rd), .i_ce_wr(ce_wr),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rd_addr(rd), .i_rd_data(wdata),
        .o_rs1_data(c_rs1), .o_rs2_data(c_rs2), .o_ready(c_rdy), .o_addr_err(c_err));

    typedef struct {
        string       tag;
        bit          chkd;
        logic [31:0] a1, a2, b1, b2, c1, c2;
        logic        ea, eb, ec;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic chk_req = 1'b0;
    logic chk_v   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t mk(input string tag, input bit chkd,
                                input logic [31:0] a1, a2, b1, b2, c1, c2,
                                input logic ea, eb, ec);
        exp_t e;
        e.tag = tag; e.chkd = chkd;
        e.a1 = a1; e.a2 = a2; e.b1 = b1; e.b2 = b2; e.c1 = c1; e.c2 = c2;
        e.ea = ea; e.eb = eb; e.ec = ec;
        return e;
    endfunction

    // Drive one cycle of stimulus; the expected response of that edge is queued.
    task automatic issue(input logic r, input logic w, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [31:0] wd, input exp_t e);
        ce_rd = r; ce_wr = w; rs1 = s1; rs2 = s2; rd = d; wdata = wd;
        q.push_back(e);
        chk_req = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        ce_rd = 1'b0; ce_wr = 1'b0; chk_req = 1'b0; clear = 1'b0;
    endtask

    // Counts edges after the sweep starts: RV32I ready after 31, RV32E after 15.
    task automatic sweep(input string name);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s.a_rdy@%0d", name, k), 32'(a_rdy), 32'(k >= 31));
            chk($sformatf("%s.b_rdy@%0d", name, k), 32'(b_rdy), 32'(k >= 31));
            chk($sformatf("%s.c_rdy@%0d", name, k), 32'(c_rdy), 32'(k >= 15));
        end
        @(negedge clk);
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".a_rdy"}, 32'(a_rdy), 0);
        chk({name, ".c_rdy"}, 32'(c_rdy), 0);
        chk({name, ".a_rs1"}, a_rs1, 0);
        chk({name, ".a_rs2"}, a_rs2, 0);
        chk({name, ".c_rs1"}, c_rs1, 0);
        chk({name, ".c_err"}, 32'(c_err), 0);
    endtask

    always @(posedge clk) chk_v <= chk_req;

    // Monitor: every edge the stimulus marked produces one queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_v) begin
                if (q.size() == 0) begin
                    chk("monitor.queue_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk({e.tag, ".a_err"}, 32'(a_err), 32'(e.ea));
                    chk({e.tag, ".b_err"}, 32'(b_err), 32'(e.eb));
                    chk({e.tag, ".c_err"}, 32'(c_err), 32'(e.ec));
                    if (e.chkd) begin
                        chk({e.tag, ".a_rs1"}, a_rs1, e.a1);
                        chk({e.tag, ".a_rs2"}, a_rs2, e.a2);
                        chk({e.tag, ".b_rs1"}, b_rs1, e.b1);
                        chk({e.tag, ".b_rs2"}, b_rs2, e.b2);
                        chk({e.tag, ".c_rs1"}, c_rs1, e.c1);
                        chk({e.tag, ".c_rs2"}, c_rs2, e.c2);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] HX = 32'h0000_1234;

    initial begin
        #12;
        chk_zero("reset");
        chk("reset.b_rdy", 32'(b_rdy), 0);
        chk("reset.a_err", 32'(a_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("sweep_rst");

        // All registers read zero after the sweep; RV32E flags x16..x31.
        for (int a = 1; a < 32; a++)
            issue(1, 0, 5'(a), 5'(a), 0, 0,
                  mk($sformatf("t1.x%0d", a), 1, 0, 0, 0, 0, 0, 0, 0, 0, (a >= 16)));

        issue(0, 1, 0, 0, 5, DB, mk("t2.wr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        issue(1, 0, 5, 0, 0, 0,  mk("t2.rd", 1, DB, 0, DB, 0, DB, 0, 0, 0, 0));

        issue(1, 1, 7, 5, 7, HX, mk("t3.byp", 1, HX, DB, 0, DB, HX, DB, 0, 0, 0));
        issue(1, 0, 7, 7, 0, 0,  mk("t3.rd", 1, HX, HX, HX, HX, HX, HX, 0, 0, 0));

        issue(1, 1, 0, 0, 0, 32'hFFFFFFFF, mk("t4.x0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        issue(1, 0, 0, 7, 0, 0, mk("t4.rd", 1, 0, HX, 0, HX, 0, HX, 0, 0, 0));

        issue(0, 1, 0, 0, 20, 5,  mk("t5.wr20", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        issue(0, 0, 0, 0, 0, 0,   mk("t5.hold", 1, 0, HX, 0, HX, 0, HX, 0, 0, 0));
        issue(1, 0, 4, 20, 0, 0,  mk("t5.rd", 1, 0, 5, 0, 5, 0, 0, 0, 0, 1));
        issue(0, 0, 0, 0, 0, 0,   mk("t5.end", 1, 0, 5, 0, 5, 0, 0, 0, 0, 0));
        issue(1, 1, 4, 4, 20, 99, mk("t5.alias", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Clear request wins over a same-cycle read and write.
        issue(0, 1, 0, 0, 3, 9, mk("t6.wr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        issue(1, 0, 3, 3, 0, 0, mk("t6.pre", 1, 9, 9, 9, 9, 9, 9, 0, 0, 0));
        chk_req = 1'b0;
        clear = 1'b1; ce_rd = 1'b1; ce_wr = 1'b1; rs1 = 3; rs2 = 5; rd = 3; wdata = 77;
        @(negedge clk);
        idle();
        chk_zero("t6.clear");
        sweep("sweep_clr");
        issue(1, 0, 3, 7, 0, 0,  mk("t6.rd", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        issue(1, 0, 5, 20, 0, 0, mk("t6.rd2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // Asynchronous reset mid-access, then again mid-sweep.
        issue(0, 1, 0, 0, 9, 32'hAA, mk("t7.wr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        issue(1, 0, 9, 9, 0, 0, mk("t7.rd", 1, 32'hAA, 32'hAA, 32'hAA, 32'hAA, 32'hAA, 32'hAA, 0, 0, 0));
        chk_req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("t7.rst_access");
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("t7.rst_sweep");
        @(negedge clk);
        rst_n = 1'b1;
        sweep("sweep_rst2");
        issue(1, 0, 9, 31, 0, 0, mk("t7.rd", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        idle();
        repeat (3) @(negedge clk);
        chk("monitor.queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
